// File: rtl/gcd_job_arbiter_pkg.sv
// ============================================================================
// gcd_job_arbiter_pkg : shared state and requester encodings for the GCD arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package gcd_job_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic REQ_BUS  = 1'b0;
  localparam logic REQ_GPIO = 1'b1;

endpackage

`default_nettype wire

// File: rtl/gcd_job_arbiter_if.sv
// ============================================================================
// gcd_job_arbiter_if : requester, response and core handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface gcd_job_arbiter_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;

  logic         rsp0_valid;
  logic [W-1:0] rsp0_result;
  logic         rsp0_err;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic [W-1:0] rsp1_result;
  logic         rsp1_err;
  logic         rsp1_ready;

  logic         core_start;
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_done;
  logic [W-1:0] core_result;

  // Arbiter view
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, core_done, core_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_err, rsp1_valid, rsp1_result, rsp1_err,
    output core_start, core_a, core_b
  );

  // Requester/core view
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, core_done, core_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err, rsp1_valid, rsp1_result, rsp1_err,
    input  core_start, core_a, core_b
  );
endinterface

`default_nettype wire

// File: rtl/gcd_job_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-input round-robin grant; pointer advances only on accept
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import gcd_job_arbiter_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       n_reset,
  input  wire logic [1:0] req,
  input  wire logic       accept,
  output logic            grant,
  output logic            any
);

  logic last_grant;

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req[1] ? REQ_GPIO : REQ_BUS;
    end
  end

  // Reset to the GPIO side so the bus path wins the first tie
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_grant <= REQ_GPIO;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gcd_job_arbiter.sv
// ============================================================================
// gcd_job_arbiter : shares one GCD core between two requesters, one job at a time
// Rev 1.0
// ============================================================================
`default_nettype none

module gcd_job_arbiter
  import gcd_job_arbiter_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  wire logic        clk,
  input  wire logic        n_reset,
  gcd_job_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] job_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t         state;
  state_t         state_nxt;
  logic           owner;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   result;
  logic           err;
  logic [TW-1:0]  timer;
  logic [CNT_W-1:0] cnt;

  logic           grant;
  logic           any;
  logic           accept;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           bypass;
  logic           owner_ready;
  logic           req0_ready;
  logic           req1_ready;
  logic           rsp0_valid;
  logic           rsp1_valid;
  logic           core_start;

  rr_arb2 u_arb (
    .clk     (clk),
    .n_reset (n_reset),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .accept  (accept),
    .grant   (grant),
    .any     (any)
  );

  assign accept      = (state == ST_IDLE) && any;
  assign sel_a       = (grant == REQ_GPIO) ? bus.req1_a : bus.req0_a;
  assign sel_b       = (grant == REQ_GPIO) ? bus.req1_b : bus.req0_b;
  assign bypass      = (sel_a == '0) || (sel_b == '0);
  assign owner_ready = (owner == REQ_GPIO) ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    core_start = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = any && (grant == REQ_BUS);
        req1_ready = any && (grant == REQ_GPIO);
        if (any) begin
          state_nxt = bypass ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done || (timer == TIMER_LAST)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid = (owner == REQ_BUS);
        rsp1_valid = (owner == REQ_GPIO);
        if (owner_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      owner  <= REQ_BUS;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      err    <= 1'b0;
      timer  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            owner  <= grant;
            op_a   <= sel_a;
            op_b   <= sel_b;
            // gcd(x,0) = x; only meaningful when the core is bypassed
            result <= (sel_a == '0) ? sel_b : sel_a;
            err    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
        end
        ST_WAIT: begin
          if (bus.core_done) begin
            result <= bus.core_result;
            err    <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (owner_ready) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.rsp0_valid  = rsp0_valid;
  assign bus.rsp1_valid  = rsp1_valid;
  assign bus.rsp0_result = rsp0_valid ? result : '0;
  assign bus.rsp1_result = rsp1_valid ? result : '0;
  assign bus.rsp0_err    = rsp0_valid & err;
  assign bus.rsp1_err    = rsp1_valid & err;
  assign bus.core_start  = core_start;
  assign bus.core_a      = op_a;
  assign bus.core_b      = op_b;
  assign busy            = (state != ST_IDLE);
  assign job_cnt         = cnt;

endmodule

`default_nettype wire

// File: tb/tb_gcd_job_arbiter.sv
// ============================================================================
// tb_gcd_job_arbiter : randomized job stream against a job-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gcd_job_arbiter;

  localparam int W       = 32;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             n_reset = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] job_cnt;

  gcd_job_arbiter_if #(.W(W)) bus ();

  gcd_job_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave),
    .busy    (busy),
    .job_cnt (job_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural GCD core: answers core_lat cycles after start, never if core_lat == 0
  int           core_lat = 0;
  int           core_cnt = 0;
  int           start_cnt = 0;
  bit           inject_done = 1'b0;
  logic [W-1:0] ca, cb;

  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (inject_done) begin
      bus.core_done   = 1'b1;
      bus.core_result = $urandom;
      inject_done     = 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.core_done   = 1'b1;
        bus.core_result = ref_gcd(ca, cb);
      end
    end
    if (bus.core_start) begin
      start_cnt++;
      core_cnt = core_lat;
      ca = bus.core_a;
      cb = bus.core_b;
    end
  end

  // Job-level model: pending requests, round-robin pointer, completed count
  bit           m_last = 1'b1;
  int           m_cnt  = 0;
  bit           p_valid [2];
  logic [W-1:0] p_a [2];
  logic [W-1:0] p_b [2];

  task automatic drive_reqs();
    bus.req0_valid = p_valid[0];
    bus.req1_valid = p_valid[1];
    bus.req0_a = p_valid[0] ? p_a[0] : W'($urandom);
    bus.req0_b = p_valid[0] ? p_b[0] : W'($urandom);
    bus.req1_a = p_valid[1] ? p_a[1] : W'($urandom);
    bus.req1_b = p_valid[1] ? p_b[1] : W'($urandom);
  endtask

  function automatic logic [W-1:0] rand_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom_range(1, 60) * $urandom_range(1, 12));
  endfunction

  task automatic serve(input int lat, input int hold);
    int           g, cyc, exp_lat;
    bit           got, byp, exp_err;
    logic [W-1:0] ea, eb, exp_res;
    int           starts0;
    @(negedge clk);
    core_lat = lat;
    drive_reqs();
    #1;
    g = (p_valid[0] && p_valid[1]) ? (m_last ? 0 : 1) : (p_valid[1] ? 1 : 0);
    check("req0_ready", bus.req0_ready, g == 0);
    check("req1_ready", bus.req1_ready, g == 1);
    ea      = p_a[g];
    eb      = p_b[g];
    byp     = (ea == 0) || (eb == 0);
    exp_err = !byp && (lat == 0);
    exp_res = byp ? (ea | eb) : ((lat == 0) ? '0 : ref_gcd(ea, eb));
    exp_lat = byp ? 1 : ((lat == 0) ? TIMEOUT + 2 : lat + 2);
    starts0 = start_cnt;
    @(posedge clk);
    m_last     = (g == 1);
    p_valid[g] = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      drive_reqs();
      bus.req0_valid = bus.req0_valid | ($urandom_range(0, 1) == 1 && g == 0 && !p_valid[0]);
      cyc++;
      #1;
      got = bus.rsp0_valid | bus.rsp1_valid;
      if (!got) begin
        check("ready_while_busy", bus.req0_ready | bus.req1_ready, 1'b0);
        if (!byp) check("core_a_held", bus.core_a, ea);
      end
    end
    check("rsp_latency", cyc, exp_lat);
    check("rsp_owner_valid", (g == 1) ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
    check("rsp_other_valid", (g == 1) ? bus.rsp0_valid : bus.rsp1_valid, 1'b0);
    check("rsp_result", (g == 1) ? bus.rsp1_result : bus.rsp0_result, exp_res);
    check("rsp_err", (g == 1) ? bus.rsp1_err : bus.rsp0_err, exp_err);
    check("core_starts", start_cnt - starts0, byp ? 0 : 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (g == 1) bus.rsp0_ready = $urandom_range(0, 1);
      else        bus.rsp1_ready = $urandom_range(0, 1);
      #1;
      check("held_result", (g == 1) ? bus.rsp1_result : bus.rsp0_result, exp_res);
      check("held_ready", bus.req0_ready | bus.req1_ready, 1'b0);
    end
    @(negedge clk);
    if (g == 1) bus.rsp1_ready = 1'b1;
    else        bus.rsp0_ready = 1'b1;
    @(posedge clk);
    m_cnt++;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("job_cnt", job_cnt, CNT_W'(m_cnt));
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.core_done = 1'b0; bus.core_result = '0;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_job_cnt", job_cnt, '0);
    check("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    check("rst_core", {bus.core_start, bus.core_a, bus.core_b}, '0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    p_valid[0] = 1'b1; p_a[0] = 422; p_b[0] = 844;
    serve(5, 0);

    p_valid[0] = 1'b1; p_a[0] = 39; p_b[0] = 9;
    p_valid[1] = 1'b1; p_a[1] = 4;  p_b[1] = 216;
    serve(3, 0);
    serve(4, 0);

    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (!p_valid[s]) begin
          p_valid[s] = 1'b1; p_a[s] = rand_op(); p_b[s] = rand_op();
        end
      end
      serve($urandom_range(1, 6), 0);
    end
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;

    p_valid[1] = 1'b1; p_a[1] = 0; p_b[1] = 27;
    serve(5, 0);
    p_valid[0] = 1'b1; p_a[0] = 0; p_b[0] = 0;
    serve(5, 0);

    p_valid[0] = 1'b1; p_a[0] = 10; p_b[0] = 15;
    serve(0, 0);
    inject_done = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("late_done_idle", {busy, bus.rsp0_valid, bus.rsp1_valid}, 3'b000);
    end

    // Requester 1 stalls the first tie, then both compete while a response is held
    p_valid[1] = 1'b1; p_a[1] = 5; p_b[1] = 35;
    serve(2, 0);
    p_valid[0] = 1'b1; p_a[0] = 12; p_b[0] = 18;
    p_valid[1] = 1'b1; p_a[1] = 7;  p_b[1] = 21;
    serve(2, 10);
    serve(2, 0);

    // Reset during WAIT
    @(negedge clk);
    core_lat = 8;
    bus.req0_valid = 1'b1; bus.req0_a = 48; bus.req0_b = 36;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("busy_in_wait", busy, 1'b1);
    n_reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_outs", {bus.rsp0_valid, bus.rsp1_valid, bus.core_start, bus.core_a, job_cnt}, '0);
    m_last = 1'b1;
    m_cnt  = 0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      check("post_rst_idle", {busy, bus.rsp0_valid, bus.rsp1_valid}, 3'b000);
    end

    for (int k = 0; k < 40; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (!p_valid[s] && $urandom_range(0, 1) == 1) begin
          p_valid[s] = 1'b1; p_a[s] = rand_op(); p_b[s] = rand_op();
        end
      end
      if (!p_valid[0] && !p_valid[1]) begin
        p_valid[0] = 1'b1; p_a[0] = rand_op(); p_b[0] = rand_op();
      end
      serve(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
